// File: rtl/instruction_sequencer.sv
// Control-unit front end: fetches an instruction, steps it through the decoder-supplied
// sub-states, latches status and gates the decoder control word onto the datapath.
module instruction_sequencer #(
    parameter int MAX_STEPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        fetch_request,
    input  logic        fetch_valid,
    input  logic [31:0] instruction_in,
    input  logic        stall,
    input  logic [4:0]  status_in,
    input  logic [32:0] decoder_controlword,
    output logic [31:0] instruction,
    output logic [1:0]  state,
    output logic [4:0]  status,
    output logic [32:0] controlword,
    output logic        executing,
    output logic        sequence_error
);

    typedef enum logic {
        PHASE_FETCH   = 1'b0,
        PHASE_EXECUTE = 1'b1
    } phase_t;

    localparam logic [3:0] STEP_LIMIT = 4'(MAX_STEPS);

    phase_t     phase;
    logic [3:0] step_count;
    logic [3:0] step_next;
    logic [1:0] cw_next_state;
    logic       cw_status_load;

    assign cw_next_state  = decoder_controlword[1:0];
    assign cw_status_load = decoder_controlword[2];
    assign step_next      = step_count + 4'd1;

    // Fetch handshake: an instruction transfers on a rising clock edge where
    // fetch_request (ready) and fetch_valid are both high; valid alone is ignored.
    assign fetch_request = (phase == PHASE_FETCH);
    assign executing     = (phase == PHASE_EXECUTE);

    // Outside a live, unstalled EXECUTE cycle every bus enable and write is forced off.
    assign controlword = (executing && !stall) ? decoder_controlword : 33'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase          <= PHASE_FETCH;
            instruction    <= 32'd0;
            state          <= 2'b00;
            status         <= 5'd0;
            step_count     <= 4'd0;
            sequence_error <= 1'b0;
        end else begin
            sequence_error <= 1'b0;
            case (phase)
                PHASE_FETCH: begin
                    if (fetch_valid) begin
                        instruction <= instruction_in;
                        state       <= 2'b00;
                        step_count  <= 4'd0;
                        phase       <= PHASE_EXECUTE;
                    end
                end
                PHASE_EXECUTE: begin
                    if (!stall) begin
                        step_count <= step_next;
                        if (cw_status_load) begin
                            status <= status_in;
                        end
                        if (cw_next_state == 2'b00) begin
                            state <= 2'b00;
                            phase <= PHASE_FETCH;
                        end else if (step_next == STEP_LIMIT) begin
                            // Runaway sequence: abandon the instruction and flag it once.
                            state          <= 2'b00;
                            phase          <= PHASE_FETCH;
                            sequence_error <= 1'b1;
                        end else begin
                            state <= cw_next_state;
                        end
                    end
                end
                default: phase <= PHASE_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: fetch, single/multi-step execute, stall,
// step-limit abort and asynchronous mid-instruction reset.
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic        fetch_valid;
    logic [31:0] instruction_in;
    logic        stall;
    logic [4:0]  status_in;
    logic [32:0] decoder_controlword;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] controlword;
    logic        executing;
    logic        sequence_error;

    int checks = 0;
    int errors = 0;

    instruction_sequencer #(.MAX_STEPS(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_request       (fetch_request),
        .fetch_valid         (fetch_valid),
        .instruction_in      (instruction_in),
        .stall               (stall),
        .status_in           (status_in),
        .decoder_controlword (decoder_controlword),
        .instruction         (instruction),
        .state               (state),
        .status              (status),
        .controlword         (controlword),
        .executing           (executing),
        .sequence_error      (sequence_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset               = 1'b1;
        fetch_valid         = 1'b0;
        instruction_in      = 32'd0;
        stall               = 1'b0;
        status_in           = 5'd0;
        decoder_controlword = 33'd0;
        #3;
        check("rst_fetch_request", 64'(fetch_request), 64'd1);
        check("rst_executing", 64'(executing), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_instruction", 64'(instruction), 64'd0);
        check("rst_controlword", 64'(controlword), 64'd0);
        check("rst_sequence_error", 64'(sequence_error), 64'd0);

        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        settle();
        check("idle_fetch_request", 64'(fetch_request), 64'd1);
        check("idle_executing", 64'(executing), 64'd0);

        // CBZ single step
        fetch_valid         = 1'b1;
        instruction_in      = 32'hB400_0041;
        decoder_controlword = 33'h0_0000_0058;
        settle();
        check("fetch_cw_gated", 64'(controlword), 64'd0);
        tick();
        fetch_valid    = 1'b0;
        instruction_in = 32'h0;
        settle();
        check("cbz_instruction", 64'(instruction), 64'hB400_0041);
        check("cbz_executing", 64'(executing), 64'd1);
        check("cbz_fetch_request", 64'(fetch_request), 64'd0);
        check("cbz_state", 64'(state), 64'd0);
        check("cbz_controlword", 64'(controlword), 64'h0_0000_0058);
        tick();
        settle();
        check("cbz_back_fetch", 64'(fetch_request), 64'd1);
        check("cbz_back_cw", 64'(controlword), 64'd0);
        check("cbz_no_seq_err", 64'(sequence_error), 64'd0);

        // Two-step instruction with a status load on the first step
        fetch_valid    = 1'b1;
        instruction_in = 32'h1234_5678;
        tick();
        fetch_valid         = 1'b0;
        decoder_controlword = 33'h0_0000_0005;
        status_in           = 5'b10101;
        settle();
        check("two_state0", 64'(state), 64'd0);
        check("two_status_before", 64'(status), 64'd0);
        tick();
        settle();
        check("two_status_loaded", 64'(status), 64'b10101);
        check("two_state1", 64'(state), 64'd1);
        check("two_still_exec", 64'(executing), 64'd1);

        // Stall in state 01: the pending status load must not happen
        stall               = 1'b1;
        decoder_controlword = 33'h1_0000_0004;
        status_in           = 5'b01010;
        settle();
        check("stall_cw_zero", 64'(controlword), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check("stall_state", 64'(state), 64'd1);
            check("stall_status", 64'(status), 64'b10101);
            check("stall_instruction", 64'(instruction), 64'h1234_5678);
            check("stall_executing", 64'(executing), 64'd1);
            check("stall_cw", 64'(controlword), 64'd0);
        end
        stall = 1'b0;
        settle();
        check("resume_cw", 64'(controlword), 64'h1_0000_0004);
        tick();
        settle();
        check("two_back_fetch", 64'(fetch_request), 64'd1);
        check("two_status_final", 64'(status), 64'b01010);
        check("two_state_final", 64'(state), 64'd0);

        // Status never changes in FETCH, even with status_load set on the bus
        decoder_controlword = 33'h0_0000_0004;
        status_in           = 5'b11111;
        tick();
        settle();
        check("fetch_status_hold", 64'(status), 64'b01010);

        // Runaway: next_state stuck at 01, with one stall cycle mid-sequence
        fetch_valid         = 1'b1;
        instruction_in      = 32'hCAFE_0001;
        decoder_controlword = 33'h0_0000_0001;
        tick();
        fetch_valid = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        settle();
        check("run_step3_exec", 64'(executing), 64'd1);
        check("run_step3_state", 64'(state), 64'd1);
        check("run_step3_no_err", 64'(sequence_error), 64'd0);
        // Fourth step also loads status; a fetch_valid offered now must be ignored
        decoder_controlword = 33'h0_0000_0005;
        status_in           = 5'b00111;
        fetch_valid         = 1'b1;
        instruction_in      = 32'hDEAD_BEEF;
        tick();
        settle();
        check("run_abort_fetch", 64'(fetch_request), 64'd1);
        check("run_abort_err", 64'(sequence_error), 64'd1);
        check("run_abort_state", 64'(state), 64'd0);
        check("run_abort_status", 64'(status), 64'b00111);
        check("run_abort_instr", 64'(instruction), 64'hCAFE_0001);
        tick();
        fetch_valid = 1'b0;
        settle();
        check("run_err_pulse", 64'(sequence_error), 64'd0);
        check("next_instr", 64'(instruction), 64'hDEAD_BEEF);
        check("next_exec", 64'(executing), 64'd1);

        // Asynchronous reset in state 01
        status_in = 5'b11000;
        tick();
        settle();
        check("pre_rst_state", 64'(state), 64'd1);
        check("pre_rst_status", 64'(status), 64'b11000);
        reset = 1'b1;
        #1;
        check("arst_fetch_request", 64'(fetch_request), 64'd1);
        check("arst_executing", 64'(executing), 64'd0);
        check("arst_state", 64'(state), 64'd0);
        check("arst_status", 64'(status), 64'd0);
        check("arst_instruction", 64'(instruction), 64'd0);
        check("arst_cw", 64'(controlword), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
